mult_iterative_sequencer: RTL and testbench

- Sequential controller for the two-row partial-product multiplier datapath.
- Accepts an operand pair over a start/ready handshake.
- Retires the multiplier operand 2 bits per cycle: one 2-row partial-product add per cycle, shifted into a 2*SIZE accumulator.
- Holds the full product on a valid/ack handshake.
- Sits between the register-file/FFD operand latches and any consumer of the product; reuses the up-counter style for iteration count.

---
 rtl/mult_iterative_sequencer_pkg.sv | 17 +
 rtl/mult_iterative_sequencer_if.sv | 31 +++
 rtl/mult_iterative_sequencer_row2.sv | 28 ++
 rtl/mult_iterative_sequencer.sv | 110 +++++++++++
 tb/tb_mult_iterative_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_iterative_sequencer_pkg.sv
// Shared types and constants for the iterative radix-4 multiplier.
// State encodings, default operand width and last-iteration helper.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_SIZE = 16;

  function automatic int last_iter(input int size);
    return size / 2 - 1;
  endfunction

endpackage

// File: rtl/mult_iterative_sequencer_if.sv
// Operand/product handshake bundle between a requester and the
// iterative multiplier.
interface mult_iterative_sequencer_if
  import mult_seq_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = 4
);

  logic              iStart;
  logic [SIZE-1:0]   iA;
  logic [SIZE-1:0]   iB;
  logic              iClear;
  logic              iAck;
  logic              oReady;
  logic              oBusy;
  logic              oValid;
  logic [2*SIZE-1:0] oProduct;
  logic [CNT_W-1:0]  oIter;

  modport master (
    output iStart, iA, iB, iClear, iAck,
    input  oReady, oBusy, oValid, oProduct, oIter
  );

  modport slave (
    input  iStart, iA, iB, iClear, iAck,
    output oReady, oBusy, oValid, oProduct, oIter
  );

endinterface

// File: rtl/mult_iterative_sequencer_row2.sv
// One radix-4 partial-product row: mcand times a 2-bit digit.
// Digit 3 is built as mcand + 2*mcand so no multiplier is needed.
module mult_row2 #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] mcand_i,
  input  logic [1:0]      digit_i,
  output logic [SIZE+1:0] row_o
);

  logic [SIZE+1:0] m1;
  logic [SIZE+1:0] m2;

  assign m1 = {2'b00, mcand_i};
  assign m2 = {1'b0, mcand_i, 1'b0};

  always_comb begin
    row_o = '0;
    unique case (digit_i)
      2'd0: row_o = '0;
      2'd1: row_o = m1;
      2'd2: row_o = m2;
      2'd3: row_o = m1 + m2;
      default: row_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_iterative_sequencer.sv
// Iterative unsigned multiplier: retires two multiplier bits per
// cycle through a single shared row, SIZE/2 cycles per product.
module mult_iterative_sequencer
  import mult_seq_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = 4
) (
  input  logic Clock,
  input  logic Reset,
  mult_iterative_sequencer_if.slave bus
);

  localparam int LAST = last_iter(SIZE);

  state_e            state_q;
  logic [SIZE-1:0]   mcand_q;
  logic [SIZE-1:0]   mplier_q;
  logic [2*SIZE-1:0] acc_q;
  logic [2*SIZE-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              valid_q;

  logic [SIZE+1:0]   row;
  logic [2*SIZE-1:0] term;
  logic [2*SIZE-1:0] acc_d;

  mult_row2 #(.SIZE(SIZE)) u_row (
    .mcand_i (mcand_q),
    .digit_i (mplier_q[1:0]),
    .row_o   (row)
  );

  always_comb begin
    term  = {{(SIZE-2){1'b0}}, row} << {cnt_q, 1'b0};
    acc_d = acc_q + term;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (bus.iClear) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.iStart) begin
            state_q  <= S_RUN;
            mcand_q  <= bus.iA;
            mplier_q <= bus.iB;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 2;
          // cnt returns to 0 on the last digit so oIter reads 0 outside RUN
          if (cnt_q == CNT_W'(LAST)) begin
            state_q <= S_DONE;
            prod_q  <= acc_d;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.iAck) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady   = ready_q;
  assign bus.oBusy    = busy_q;
  assign bus.oValid   = valid_q;
  assign bus.oProduct = prod_q;
  assign bus.oIter    = cnt_q;

endmodule

// File: tb/tb_mult_iterative_sequencer.sv
// Scoreboard bench: stimulus queues a*b with its accept cycle, a
// monitor checks product, 8-cycle latency and hold stability.
module tb_mult_iterative_sequencer;

  localparam int SIZE  = 16;
  localparam int CNT_W = 4;
  localparam int LAT   = SIZE / 2;

  typedef struct {
    logic [31:0] prod;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];
  logic vprev;
  logic [31:0] held;

  mult_iterative_sequencer_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  mult_iterative_sequencer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on each oValid rise, then require a stable product.
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev = 1'b0;
    end else begin
      if (bus.oValid && !vprev) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          held = e.prod;
          check("product", bus.oProduct, e.prod);
          check("latency", cyc - e.acc, LAT);
        end
      end else if (bus.oValid && vprev) begin
        check("hold", bus.oProduct, held);
      end
      vprev = bus.oValid;
    end
  end

  task automatic start_job(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.oReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.oReady, 1);
    bus.iA     = a;
    bus.iB     = b;
    bus.iStart = 1'b1;
    q.push_back('{32'(a) * 32'(b), cyc + 1});
    @(negedge clk);
    bus.iStart = 1'b0;
    check("accept_ready", bus.oReady, 0);
    check("accept_busy", bus.oBusy, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.oValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", bus.oValid, 1);
  endtask

  task automatic wait_iter(input int k);
    int n;
    n = 0;
    while (int'(bus.oIter) != k && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("iter_wait", bus.oIter, k);
  endtask

  task automatic do_ack();
    bus.iAck = 1'b1;
    @(negedge clk);
    bus.iAck = 1'b0;
    check("ack_ready", bus.oReady, 1);
    check("ack_valid", bus.oValid, 0);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_ready"}, bus.oReady, 1);
    check({nm, "_busy"}, bus.oBusy, 0);
    check({nm, "_valid"}, bus.oValid, 0);
    check({nm, "_prod"}, bus.oProduct, 0);
    check({nm, "_iter"}, bus.oIter, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vprev = 1'b0;
    held  = '0;
    rst_n = 1'b0;
    bus.iStart = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iClear = 1'b0;
    bus.iAck   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    start_job(16'd3, 16'd5);
    @(negedge clk);
    check("iter_run", bus.oIter, 1);
    wait_valid();
    check("iter_done", bus.oIter, 0);
    do_ack();
    check("prod_after_ack", bus.oProduct, 32'd15);

    start_job(16'hFFFF, 16'hFFFF);
    wait_valid();
    check("max_prod", bus.oProduct, 32'hFFFE0001);
    do_ack();

    start_job(16'h1234, 16'd0);
    wait_valid();
    do_ack();
    start_job(16'd0, 16'hABCD);
    wait_valid();
    do_ack();

    start_job(16'd3, 16'd5);
    repeat (2) @(negedge clk);
    bus.iA     = 16'd7;
    bus.iB     = 16'd9;
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    wait_valid();
    repeat (20) @(negedge clk);
    check("hold20_valid", bus.oValid, 1);
    check("hold20_prod", bus.oProduct, 32'd15);
    do_ack();

    start_job(16'h00FF, 16'h0101);
    wait_iter(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_job(16'd2, 16'd3);
    wait_valid();
    do_ack();

    start_job(16'd9, 16'd9);
    wait_valid();
    bus.iClear = 1'b1;
    bus.iAck   = 1'b1;
    @(negedge clk);
    bus.iClear = 1'b0;
    bus.iAck   = 1'b0;
    check_idle("clr_done");

    start_job(16'd11, 16'd13);
    wait_iter(2);
    bus.iClear = 1'b1;
    q.delete();
    @(negedge clk);
    bus.iClear = 1'b0;
    check_idle("clr_run");
    start_job(16'd100, 16'd200);
    wait_valid();
    check("prod_20000", bus.oProduct, 32'd20000);

    bus.iAck   = 1'b1;
    bus.iStart = 1'b1;
    bus.iA     = 16'd5;
    bus.iB     = 16'd5;
    @(negedge clk);
    bus.iAck   = 1'b0;
    bus.iStart = 1'b0;
    check("ack_start_ready", bus.oReady, 1);
    check("ack_start_busy", bus.oBusy, 0);
    check("ack_start_prod", bus.oProduct, 32'd20000);

    for (int i = 0; i < 20; i++) begin
      start_job(16'($urandom), 16'($urandom));
      wait_valid();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack();
    end

    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
